// File: rtl/pmem_responder.sv
// Single-outstanding memory responder: request, programmable access latency, then held response.
// The physical memory behind v_pmem_read/v_pmem_write is a small word array aliased over the legal window.
module pmem_responder #(
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE  = 32'h0800_0000,
  parameter int unsigned PMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_is_write
);

  if (LATENCY == 0) begin : g_bad_latency
    $error("pmem_responder: LATENCY must be at least 1");
  end

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (PMEM_WORDS > 1) ? $clog2(PMEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          valid_q, valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          is_write_q, is_write_d;

  logic [31:0]   pmem_q [PMEM_WORDS];
  logic [31:0]   rd_calls_q;
  logic [31:0]   wr_calls_q;
  logic          do_rd, do_wr;
  logic          addr_err;
  logic [31:0]   word_addr;

  function automatic logic [IW-1:0] pmem_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - ADDR_BASE) >> 2;
    return off[IW-1:0];
  endfunction

  function automatic logic [31:0] v_pmem_read(input logic [31:0] a);
    return pmem_q[pmem_idx(a)];
  endfunction

  // Unsigned difference makes addresses below the base wrap to huge offsets.
  assign addr_err  = (addr_q - ADDR_BASE) >= ADDR_SIZE;
  assign word_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    valid_d    = valid_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    is_write_d = is_write_q;
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d    = RESP;
          valid_d    = 1'b1;
          is_write_d = wen_q;
          err_d      = addr_err;
          rdata_d    = '0;
          if (!addr_err) begin
            if (!wen_q) begin
              do_rd   = 1'b1;
              rdata_d = v_pmem_read(word_addr);
            end else if (wmask_q != 4'b0000) begin
              do_wr = 1'b1;
            end
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      is_write_q <= is_write_d;
    end
  end

  // Memory contents and call counts survive reset, like the external memory they stand in for.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_q[b]) pmem_q[pmem_idx(word_addr)][8*b +: 8] <= wdata_q[8*b +: 8];
        end
        wr_calls_q <= wr_calls_q + 32'd1;
      end
      if (do_rd) rd_calls_q <= rd_calls_q + 32'd1;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = valid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_is_write = is_write_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: three instances with LATENCY 1, 3 and 4 share request/response buses.
module tb_pmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [2:0]  resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata [3];
  logic [2:0]  resp_err;
  logic [2:0]  resp_is_write;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd0, wr1, wr2;

  localparam int unsigned LAT [3] = '{1, 3, 4};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pmem_responder #(.LATENCY(LAT[g])) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .resp_is_write(resp_is_write[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (it is accepted there), then wait out the latency.
  task automatic issue(input int i, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    req_wen = wen; req_addr = a; req_wdata = d; req_wmask = m;
    req_valid[i] = 1'b1;
    tick();
    req_valid[i] = 1'b0;
    chk("busy_ready", {31'd0, req_ready[i]}, 32'd0);
    for (int k = 1; k < int'(LAT[i]); k++) begin
      tick();
      chk("early_valid", {31'd0, resp_valid[i]}, 32'd0);
    end
    tick();
    chk("resp_valid", {31'd0, resp_valid[i]}, 32'd1);
  endtask

  task automatic handshake(input int i);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("hs_valid", {31'd0, resp_valid[i]}, 32'd0);
    chk("hs_ready", {31'd0, req_ready[i]}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", {29'd0, req_ready}, 32'd7);
    chk("rst_resp_valid", {29'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'd0);
    chk("rst_err", {29'd0, resp_err}, 32'd0);
    chk("rst_is_write", {29'd0, resp_is_write}, 32'd0);

    // Latency 1: preload a word, then read it back from an unaligned address.
    issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    handshake(0);
    rd0 = g_dut[0].u_dut.rd_calls_q;
    issue(0, 1'b0, 32'h8000_0012, 32'h0, 4'h0);
    chk("rd_data", resp_rdata[0], 32'hDEAD_BEEF);
    chk("rd_err", {31'd0, resp_err[0]}, 32'd0);
    chk("rd_is_write", {31'd0, resp_is_write[0]}, 32'd0);
    chk("rd_calls", g_dut[0].u_dut.rd_calls_q - rd0, 32'd1);
    handshake(0);

    // Latency 3: masked write lands on the third edge and merges only the low two lanes.
    issue(1, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF);
    handshake(1);
    wr1 = g_dut[1].u_dut.wr_calls_q;
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1122_3344; req_wmask = 4'b0011;
    req_valid[1] = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    tick(); tick();
    chk("wr_not_yet", g_dut[1].u_dut.wr_calls_q - wr1, 32'd0);
    chk("wr_not_valid", {31'd0, resp_valid[1]}, 32'd0);
    tick();
    chk("wr_valid", {31'd0, resp_valid[1]}, 32'd1);
    chk("wr_calls", g_dut[1].u_dut.wr_calls_q - wr1, 32'd1);
    chk("wr_rdata", resp_rdata[1], 32'd0);
    chk("wr_is_write", {31'd0, resp_is_write[1]}, 32'd1);
    handshake(1);
    issue(1, 1'b0, 32'h8000_0023, 32'h0, 4'h0);
    chk("wr_merge", resp_rdata[1], 32'hAABB_3344);
    handshake(1);

    // Out-of-range reads on both sides of the window, and the last legal word.
    rd0 = g_dut[0].u_dut.rd_calls_q;
    issue(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    chk("lo_err", {31'd0, resp_err[0]}, 32'd1);
    chk("lo_rdata", resp_rdata[0], 32'd0);
    handshake(0);
    issue(0, 1'b0, 32'h8800_0000, 32'h0, 4'h0);
    chk("hi_err", {31'd0, resp_err[0]}, 32'd1);
    chk("hi_rdata", resp_rdata[0], 32'd0);
    handshake(0);
    chk("oor_rd_calls", g_dut[0].u_dut.rd_calls_q - rd0, 32'd0);
    issue(0, 1'b0, 32'h87FF_FFFC, 32'h0, 4'h0);
    chk("top_err", {31'd0, resp_err[0]}, 32'd0);
    handshake(0);

    // Back-pressure with a competing request and churning request fields.
    rd0 = g_dut[0].u_dut.rd_calls_q;
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    req_valid[0] = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
    req_wdata = 32'h0BAD_F00D; req_wmask = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'd0, resp_valid[0]}, 32'd1);
      chk("bp_rdata", resp_rdata[0], 32'hDEAD_BEEF);
      chk("bp_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    handshake(0);
    chk("bp_rd_calls", g_dut[0].u_dut.rd_calls_q - rd0, 32'd1);
    chk("bp_is_write", {31'd0, resp_is_write[0]}, 32'd0);
    issue(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    chk("bp_mem_intact", resp_rdata[0], 32'hDEAD_BEEF);
    handshake(0);

    // Latency 4: reset during BUSY abandons the write.
    wr2 = g_dut[2].u_dut.wr_calls_q;
    req_wen = 1'b1; req_addr = 32'h8000_0040; req_wdata = 32'h5555_5555; req_wmask = 4'hF;
    req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_valid", {31'd0, resp_valid[2]}, 32'd0);
    chk("rb_ready", {31'd0, req_ready[2]}, 32'd1);
    tick(); tick(); tick();
    chk("rb_wr_calls", g_dut[2].u_dut.wr_calls_q - wr2, 32'd0);
    chk("rb_still_idle", {31'd0, resp_valid[2]}, 32'd0);

    // Zero-mask write: normal response, no memory call.
    issue(2, 1'b1, 32'h8000_0044, 32'hFFFF_FFFF, 4'h0);
    chk("z_err", {31'd0, resp_err[2]}, 32'd0);
    chk("z_is_write", {31'd0, resp_is_write[2]}, 32'd1);
    chk("z_rdata", resp_rdata[2], 32'd0);
    chk("z_wr_calls", g_dut[2].u_dut.wr_calls_q - wr2, 32'd0);
    handshake(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Memory-side responder for the core's load/store and fetch requests: accepts one request at a time over a valid/ready request channel.
- Performs the physical-memory access through the DPI functions v_pmem_read / v_pmem_write after a programmable latency.
- Returns the result over a valid/ready response channel.
- Replaces the core's direct combinational DPI memory calls, so the multi-cycle core and a future bus can be exercised against realistic latency.

Parameters:
- LATENCY, 1, edge count from request acceptance to resp_valid rising; minimum 1, elaboration error if 0.
- ADDR_BASE, 32'h80000000, lowest legal physical address.
- ADDR_SIZE, 32'h08000000, size in bytes of the legal window.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte-lane write enables.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  read data; 0 for writes and errors.
- resp_err  output  1  address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE).
- resp_is_write  output  1  echoes req_wen of the completed request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - State = IDLE.
  - req_ready = 1 after the reset edge.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, resp_is_write = 0.
  - Latency counter = 0; latched request fields = 0.
- States: IDLE, BUSY, RESP.
- req_ready = (state == IDLE), driven combinationally from state only; no dependence on req_valid.
- IDLE:
  - On an edge with req_valid & req_ready, latch req_wen, req_addr, req_wdata and req_wmask.
  - Load the counter with LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, on each edge:
  - If counter != 0: decrement the counter and stay in BUSY.
  - If counter == 0: perform the access on this edge and go to RESP with resp_valid = 1.
- Access rules:
  - Range check uses 32-bit unsigned arithmetic: err = (addr - ADDR_BASE) >= ADDR_SIZE. Addresses below ADDR_BASE wrap around and are therefore out of range.
  - err = 1: no DPI call; resp_rdata = 0, resp_err = 1.
  - Read: resp_rdata = v_pmem_read(addr & ~3). Exactly one call per request, made on the access edge.
  - Write with wmask != 0: exactly one call, v_pmem_write(addr & ~3, wdata, {4'b0, wmask}). resp_rdata = 0.
  - Write with wmask == 0: no DPI call; responds normally with resp_err = 0.
  - addr[1:0] is ignored; no misalignment error.
- Latency: a request accepted at edge E0 has its access performed at edge E0+LATENCY. resp_valid is high in the cycle after that edge.
- RESP:
  - resp_valid, resp_rdata, resp_err and resp_is_write are held stable until the response handshake.
  - On an edge with resp_valid & resp_ready, clear resp_valid and go to IDLE. resp_rdata keeps its last value.
  - req_ready is 0 throughout RESP. A new request is accepted at the earliest one cycle after the response handshake; there is no same-cycle overlap of response and request.
- Back-pressure: resp_ready held low any number of cycles keeps the responder in RESP, with no extra DPI calls.
- Request stability: req_* inputs changing while state != IDLE have no effect.
- Reset mid-operation:
  - Reset in BUSY before the access edge abandons the request; no DPI call is made.
  - Reset in RESP drops the response; a write already performed is not undone.
  - Reset has priority over every transition on the same edge.

Test Plan:
- LATENCY=1, memory word 0x80000010 = 0xDEADBEEF, read addr 0x80000012 accepted at E0 -> resp_valid=1 after E1, resp_rdata=0xDEADBEEF, resp_err=0, resp_is_write=0. req_ready=0 until the cycle after the response handshake.
- LATENCY=3, write addr 0x80000020, wdata 0x11223344, wmask 4'b0011 -> exactly one v_pmem_write(0x80000020, 0x11223344, 8'h03), performed at E3. resp_valid after E3; resp_rdata=0.
- Read addr 0x7FFFFFFC, then read addr 0x88000000 -> resp_err=1 and resp_rdata=0 for both; no v_pmem_read calls (DPI call counter unchanged).
- resp_ready held low 5 cycles after resp_valid -> outputs stable for all 5 cycles, req_ready=0, no additional DPI calls. Raising resp_ready completes the handshake; req_ready=1 the next cycle.
- LATENCY=4, write accepted, rst asserted for one edge at E2 -> zero v_pmem_write calls; state IDLE, resp_valid=0, req_ready=1 after the reset edge.
- Write with wmask=4'b0000 -> no DPI call; resp_valid with resp_err=0, resp_is_write=1.
